// File: rtl/seg_pkg.sv
// Shared constants, scan-state encoding and width helper for the seven-segment scan driver.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Scan-slot counter: counts 0..SLOT_CYC-1 while enabled and flags the slot wrap
// and the last dead-time cycle one cycle ahead so the FSM can register its outputs.
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int SLOT_CYC = 50000,
  parameter int DEAD_CYC = 16,
  localparam int CNT_W   = clog2(SLOT_CYC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic slot_wrap,
  output logic dead_done
);

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign slot_wrap = en && (cnt == LAST);
  assign dead_done = en && (cnt == DEAD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || slot_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment scan driver with per-slot dead-time.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int DEAD_CYC   = 16,
  localparam int IDX_W     = (clog2(NUM_DIGITS) > 0) ? clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              pin_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    blank,
  output logic [IDX_W-1:0]        dig_idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                    slot_wrap;
  logic                    dead_done;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] shadow_n;
  scan_state_t             state;
  scan_state_t             state_n;
  logic [IDX_W-1:0]        idx_n;
  logic [NUM_DIGITS-1:0]   an_n_n;
  logic                    blank_n;

  seg_scan_tick #(
    .SLOT_CYC (SLOT_CYC),
    .DEAD_CYC (DEAD_CYC)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .slot_wrap (slot_wrap),
    .dead_done (dead_done)
  );

`ifdef SEG_SCAN_LZB_EN
  // True when digit k is above 0 and it and every more significant digit are zero.
  function automatic logic lzb_mask(input logic [4*NUM_DIGITS-1:0] sh,
                                    input logic [IDX_W-1:0]        k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(k)) && (sh[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    return (k != '0) && upper_zero;
  endfunction
`endif

  // Next-state values; outputs are registered from these so they align with the counter.
  always_comb begin
    shadow_n = load ? digits_in : shadow;
    idx_n    = dig_idx;
    if (slot_wrap) idx_n = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    state_n = state;
    if (!en || slot_wrap) state_n = ST_DEAD;
    else if (dead_done)   state_n = ST_SHOW;
    an_n_n = '1;
    if (state_n == ST_SHOW) an_n_n[idx_n] = 1'b0;
    blank_n = (state_n == ST_DEAD);
`ifdef SEG_SCAN_LZB_EN
    if ((state_n == ST_SHOW) && lzb_mask(shadow_n, idx_n)) blank_n = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      state   <= ST_DEAD;
      dig_idx <= '0;
      pin_out <= 4'd0;
      an_n    <= '1;
      blank   <= 1'b1;
    end else begin
      shadow  <= shadow_n;
      state   <= state_n;
      dig_idx <= idx_n;
      an_n    <= an_n_n;
      blank   <= blank_n;
      // Old shadow is sampled here so a coincident load shows on the digit's next slot.
      if (slot_wrap) pin_out <= shadow[{idx_n, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (NUM_DIGITS=4, SLOT_CYC=8, DEAD_CYC=2);
// define SEG_SCAN_LZB_EN to exercise leading-zero blanking.
module tb_seven_seg_scan;
  import seg_pkg::*;

  localparam int N    = 4;
  localparam int SLOT = 8;
  localparam int DEAD = 2;
`ifdef SEG_SCAN_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  pin_out;
  logic [3:0]  an_n;
  logic        blank;
  logic [1:0]  dig_idx;
  logic [6:0]  seg_gated;

  seven_seg_scan #(
    .NUM_DIGITS (N),
    .SLOT_CYC   (SLOT),
    .DEAD_CYC   (DEAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .pin_out   (pin_out),
    .an_n      (an_n),
    .blank     (blank),
    .dig_idx   (dig_idx)
  );

  always #5 clk = ~clk;

  // Downstream gating as seven_seg_disp would apply it.
  assign seg_gated = blank ? SEG_OFF : {3'b000, pin_out};

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  // Behavioural model: slot position, current digit, latched nibble, shadow digits.
  int          m_pos = 0;
  int          m_idx = 0;
  logic [3:0]  m_pin = 4'h0;
  logic [15:0] m_sh  = 16'h0;
  logic [15:0] old_sh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0;
      m_idx = 0;
      m_pin = 4'h0;
      m_sh  = 16'h0;
    end else begin
      old_sh = m_sh;
      if (load) m_sh = digits_in;
      if (!en) begin
        m_pos = 0;
      end else if (m_pos == SLOT - 1) begin
        m_pos = 0;
        m_idx = (m_idx + 1) % N;
        m_pin = old_sh[m_idx*4 +: 4];
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  function automatic logic m_lzb(input logic [15:0] sh, input int k);
    if (!LZB || k == 0) return 1'b0;
    for (int i = k; i < N; i++) begin
      if (sh[i*4 +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic       show;
    logic [3:0] e_an;
    logic       e_blank;
    #1;
    if (chk_on) begin
      show    = (m_pos >= DEAD);
      e_an    = show ? ~(4'b0001 << m_idx) : 4'hF;
      e_blank = !show || m_lzb(m_sh, m_idx);
      chk("an_n", 32'(an_n), 32'(e_an));
      chk("blank", 32'(blank), 32'(e_blank));
      chk("pin_out", 32'(pin_out), 32'(m_pin));
      chk("dig_idx", 32'(dig_idx), 32'(m_idx));
      chk("seg_gated", 32'(seg_gated), 32'(e_blank ? 7'h7F : {3'b000, m_pin}));
      chk("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] a, input logic b,
                            input logic [3:0] p, input logic [1:0] k);
    chk({nm, "_an"}, 32'(an_n), 32'(a));
    chk({nm, "_blank"}, 32'(blank), 32'(b));
    chk({nm, "_pin"}, 32'(pin_out), 32'(p));
    chk({nm, "_idx"}, 32'(dig_idx), 32'(k));
  endtask

  initial begin
    // Reset state
    tick(2);
    chk_on = 1'b1;
    expect_out("reset", 4'hF, 1'b1, 4'h0, 2'd0);

    // Walk through all four digits after loading 1234
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1; load = 1'b1; digits_in = 16'h1234;
    tick(1);
    @(negedge clk);
    load = 1'b0;
    tick(1);
    expect_out("t1_d0_first", 4'b1110, 1'b0, 4'h0, 2'd0);
    tick(8);
    expect_out("t1_d1", 4'b1101, 1'b0, 4'h3, 2'd1);
    tick(8);
    expect_out("t1_d2", 4'b1011, 1'b0, 4'h2, 2'd2);
    tick(8);
    expect_out("t1_d3", 4'b0111, 1'b0, 4'h1, 2'd3);
    tick(6);
    expect_out("t2_dead", 4'hF, 1'b1, 4'h4, 2'd0);
    tick(2);
    expect_out("t1_d0", 4'b1110, 1'b0, 4'h4, 2'd0);

    // Load mid-slot of digit 2 must not tear the displayed nibble
    tick(17);
    expect_out("t3_pre", 4'b1011, 1'b0, 4'h2, 2'd2);
    @(negedge clk);
    load = 1'b1; digits_in = 16'hABCD;
    tick(1);
    @(negedge clk);
    load = 1'b0;
    tick(3);
    expect_out("t3_hold", 4'b1011, 1'b0, 4'h2, 2'd2);
    tick(1);
    expect_out("t3_next", 4'hF, 1'b1, 4'hA, 2'd3);
    tick(26);
    expect_out("t3_d2_new", 4'b1011, 1'b0, 4'hB, 2'd2);

    // Drop en for five clocks during SHOW
    @(negedge clk);
    en = 1'b0;
    tick(1);
    expect_out("t4_off", 4'hF, 1'b1, 4'hB, 2'd2);
    tick(4);
    @(negedge clk);
    en = 1'b1;
    tick(1);
    expect_out("t4_dead", 4'hF, 1'b1, 4'hB, 2'd2);
    tick(1);
    expect_out("t4_show", 4'b1011, 1'b0, 4'hB, 2'd2);

    // Asynchronous reset in the middle of SHOW
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t5_async", 4'hF, 1'b1, 4'h0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; load = 1'b1; digits_in = 16'h0050;
    tick(1);
    @(negedge clk);
    load = 1'b0;
    tick(1);
    expect_out("t5_restart", 4'b1110, 1'b0, 4'h0, 2'd0);

    // Leading-zero pattern 0050, then all zeros
    tick(8);
    expect_out("t6_d1", 4'b1101, 1'b0, 4'h5, 2'd1);
    tick(8);
    expect_out("t6_d2", 4'b1011, LZB, 4'h0, 2'd2);
    tick(8);
    expect_out("t6_d3", 4'b0111, LZB, 4'h0, 2'd3);
    @(negedge clk);
    load = 1'b1; digits_in = 16'h0000;
    tick(1);
    @(negedge clk);
    load = 1'b0;
    tick(7);
    expect_out("t6_z_d0", 4'b1110, 1'b0, 4'h0, 2'd0);
    tick(8);
    expect_out("t6_z_d1", 4'b1101, LZB, 4'h0, 2'd1);
    tick(4);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
